// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, per-op latencies, destination decode and
// the issue-stage state encoding. Imported by the FPU datapath and by fpu_issue.
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_FADD   = 4'b0000,
    OP_FSUB   = 4'b0001,
    OP_FMUL   = 4'b0010,
    OP_FDIV   = 4'b0011,
    OP_FSQRT  = 4'b0100,
    OP_FSGNJ  = 4'b0101,
    OP_FSGNJN = 4'b0110,
    OP_FSGNJX = 4'b0111,
    OP_FEQ    = 4'b1000,
    OP_FLT    = 4'b1001,
    OP_FLE    = 4'b1010,
    OP_FCVTWS = 4'b1011,
    OP_FCVTSW = 4'b1100,
    OP_NOP    = 4'b1111
  } fpuop_t;

  localparam logic [3:0] FPU_NOP = 4'b1111;

  localparam int unsigned LAT_FADD   = 3;
  localparam int unsigned LAT_FSUB   = 3;
  localparam int unsigned LAT_FMUL   = 2;
  localparam int unsigned LAT_FDIV   = 11;
  localparam int unsigned LAT_FSQRT  = 7;
  localparam int unsigned LAT_FCVTSW = 2;
  localparam int unsigned LAT_FCVTWS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } issue_state_t;

  // Cycles the FPU needs beyond the first; unlisted and unsupported ops are single-cycle.
  function automatic int unsigned fpu_latency(input logic [3:0] op);
    case (op)
      OP_FADD:   return LAT_FADD;
      OP_FSUB:   return LAT_FSUB;
      OP_FMUL:   return LAT_FMUL;
      OP_FDIV:   return LAT_FDIV;
      OP_FSQRT:  return LAT_FSQRT;
      OP_FCVTSW: return LAT_FCVTSW;
      OP_FCVTWS: return LAT_FCVTWS;
      default:   return 0;
    endcase
  endfunction

  // Compares and float-to-int conversion (1000..1011) write the integer RF.
  function automatic logic is_int_dest(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/fpu_issue.sv
// Issue stage in front of the FPU: accepts one op, holds it on the FPU inputs
// until fin, then buffers the result for writeback. Includes flush and a hang watchdog.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 31,
  parameter int unsigned RD_W           = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [31:0]     req_src0,
  input  logic [31:0]     req_src1,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic [3:0]      fpu_op,
  output logic [31:0]     fpu_src0,
  output logic [31:0]     fpu_src1,
  input  logic [31:0]     fpu_result,
  input  logic            fpu_fin,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_int,
  output logic            busy,
  output logic            err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  issue_state_t    state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     src0_q, src0_d;
  logic [31:0]     src1_q, src1_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [RD_W-1:0] resp_rd_q, resp_rd_d;
  logic            resp_int_q, resp_int_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            accept;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = !flush;
      ST_HOLD: req_ready = resp_ready && !flush;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src0_d       = src0_q;
    src1_d       = src1_q;
    rd_d         = rd_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_int_d   = resp_int_q;
    err_d        = err_q;
    wdog_d       = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        wdog_d = wdog_q + WD_W'(1);
        // Flush wins over a same-cycle fin; the result is simply dropped.
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (fpu_fin) begin
          resp_valid_d = 1'b1;
          resp_data_d  = fpu_result;
          resp_rd_d    = rd_q;
          resp_int_d   = is_int_dest(op_q);
          state_d      = ST_HOLD;
        end else if (wdog_d == WD_W'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = accept ? ST_EXEC : ST_IDLE;
        end
      end
      // One NOP cycle lets the FPU's internal counter return to zero.
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      op_d   = req_op;
      src0_d = req_src0;
      src1_d = req_src1;
      rd_d   = req_rd;
      wdog_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers, including the
  // operand latches, reset so the FPU sees NOP and zero operands straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      src0_q       <= '0;
      src1_q       <= '0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_int_q   <= 1'b0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src0_q       <= src0_d;
      src1_q       <= src1_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_int_q   <= resp_int_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
    end
  end

  assign fpu_op     = (state_q == ST_EXEC) ? op_q : FPU_NOP;
  assign fpu_src0   = src0_q;
  assign fpu_src1   = src1_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_int   = resp_int_q;
  assign busy       = state_q != ST_IDLE;
  assign err        = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with a small latency-accurate FPU model
// (fin after the op's latency, optional hang stub).
module tb_fpu_issue;
  import fpu_pkg::*;

  localparam int unsigned RD_W = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_op = '0;
  logic [31:0]     req_src0 = '0;
  logic [31:0]     req_src1 = '0;
  logic [RD_W-1:0] req_rd = '0;
  logic            flush = 1'b0;
  logic [3:0]      fpu_op;
  logic [31:0]     fpu_src0;
  logic [31:0]     fpu_src1;
  logic [31:0]     fpu_result;
  logic            fpu_fin;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [31:0]     resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            resp_int;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_pass   = 0;

  logic        hang = 1'b0;
  logic [31:0] model_result = '0;
  int unsigned fpu_cnt = 0;

  always #5 clk = ~clk;

  fpu_issue #(.TIMEOUT_CYCLES(31), .RD_W(RD_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src0(req_src0), .req_src1(req_src1), .req_rd(req_rd),
    .flush(flush),
    .fpu_op(fpu_op), .fpu_src0(fpu_src0), .fpu_src1(fpu_src1),
    .fpu_result(fpu_result), .fpu_fin(fpu_fin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_int(resp_int),
    .busy(busy), .err(err)
  );

  // FPU model: fin once the op has been held for its latency; NOP is single-cycle.
  assign fpu_fin = (fpu_op == FPU_NOP) || (!hang && fpu_cnt == fpu_latency(fpu_op));

  always_comb begin
    fpu_result = model_result;
    case (fpu_op)
      4'b0101: fpu_result = {fpu_src1[31], fpu_src0[30:0]};
      4'b0110: fpu_result = {~fpu_src1[31], fpu_src0[30:0]};
      4'b1101, 4'b1110: fpu_result = 32'h0;
      default: fpu_result = model_result;
    endcase
  end

  always @(posedge clk) begin
    if (fpu_op == FPU_NOP || fpu_fin) fpu_cnt <= 0;
    else fpu_cnt <= fpu_cnt + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE and return just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [RD_W-1:0] rd);
    req_op = op; req_src0 = a; req_src1 = b; req_rd = rd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #12;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err got=%0h exp=0", err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0h exp=0", busy); else n_pass++;
    n_checks++; if (fpu_op !== 4'hF) $display("FAIL rst_fpu_op got=%0h exp=f", fpu_op); else n_pass++;
    n_checks++; if ({resp_data, resp_rd, resp_int} !== '0) $display("FAIL rst_resp got=%0h/%0h/%0h exp=0", resp_data, resp_rd, resp_int); else n_pass++;
    n_checks++; if ({fpu_src0, fpu_src1} !== 64'h0) $display("FAIL rst_src got=%0h/%0h exp=0", fpu_src0, fpu_src1); else n_pass++;
    #3 rstn = 1'b1;
    tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got=%0h exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_fsgnj;
    resp_ready = 1'b1;
    send(4'b0101, 32'h3F800000, 32'hBF800000, 5'd2);
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL fsgnj_early_valid got=%0h exp=0", resp_valid); else n_pass++;
    n_checks++; if (fpu_op !== 4'b0101) $display("FAIL fsgnj_fpu_op got=%0h exp=5", fpu_op); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL fsgnj_valid got=%0h exp=1", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 32'hBF800000) $display("FAIL fsgnj_data got=%0h exp=bf800000", resp_data); else n_pass++;
    n_checks++; if (resp_int !== 1'b0 || resp_rd !== 5'd2) $display("FAIL fsgnj_int_rd got=%0h/%0h exp=0/2", resp_int, resp_rd); else n_pass++;
    n_checks++; if (fpu_op !== 4'hF) $display("FAIL fsgnj_hold_nop got=%0h exp=f", fpu_op); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fsgnj_done got=%0h/%0h exp=0/0", resp_valid, busy); else n_pass++;
  endtask

  task automatic test_fadd;
    model_result = 32'h40400000;
    send(4'b0000, 32'h3F800000, 32'h40000000, 5'd7);
    req_src0 = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (fpu_op !== 4'b0000 || fpu_src0 !== 32'h3F800000 || resp_valid !== 1'b0)
        $display("FAIL fadd_exec_c%0d got=%0h/%0h/%0h exp=0/3f800000/0", i, fpu_op, fpu_src0, resp_valid); else n_pass++;
      tick();
    end
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h40400000 || resp_rd !== 5'd7)
      $display("FAIL fadd_resp got=%0h/%0h/%0h exp=1/40400000/7", resp_valid, resp_data, resp_rd); else n_pass++;
    tick();
  endtask

  task automatic test_hold_b2b;
    model_result = 32'h40C00000;
    resp_ready = 1'b0;
    send(4'b0010, 32'h40000000, 32'h40400000, 5'd4);
    tick(3);
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h40C00000)
      $display("FAIL fmul_resp got=%0h/%0h exp=1/40c00000", resp_valid, resp_data); else n_pass++;
    req_op = 4'b0110; req_src0 = 32'h3F800000; req_src1 = 32'h3F800000; req_rd = 5'd9; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h40C00000 || resp_rd !== 5'd4 || req_ready !== 1'b0)
        $display("FAIL hold_stable_c%0d got=%0h/%0h/%0h/%0h exp=1/40c00000/4/0", i, resp_valid, resp_data, resp_rd, req_ready); else n_pass++;
      tick();
    end
    resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_req_ready got=%0h exp=1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++; if (fpu_op !== 4'b0110 || resp_valid !== 1'b0)
      $display("FAIL b2b_exec got=%0h/%0h exp=6/0", fpu_op, resp_valid); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hBF800000 || resp_rd !== 5'd9)
      $display("FAIL b2b_resp got=%0h/%0h/%0h exp=1/bf800000/9", resp_valid, resp_data, resp_rd); else n_pass++;
    tick();
  endtask

  task automatic test_flush_exec;
    model_result = 32'h3F000000;
    send(4'b0011, 32'h3F800000, 32'h40000000, 5'd1);
    tick(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (fpu_op !== 4'hF || busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL flush_drain got=%0h/%0h/%0h/%0h exp=f/1/0/0", fpu_op, busy, resp_valid, req_ready); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL flush_idle got=%0h/%0h exp=0/0", busy, resp_valid); else n_pass++;
    model_result = 32'd3;
    send(4'b1011, 32'h40400000, 32'h0, 5'd3);
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL fcvtws_early got=%0h exp=0", resp_valid); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd3 || resp_int !== 1'b1 || resp_rd !== 5'd3)
      $display("FAIL fcvtws_resp got=%0h/%0h/%0h/%0h exp=1/3/1/3", resp_valid, resp_data, resp_int, resp_rd); else n_pass++;
    tick();
  endtask

  task automatic test_flush_hold;
    resp_ready = 1'b0;
    send(4'b0101, 32'h3F800000, 32'h00000000, 5'd5);
    tick();
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL fhold_valid got=%0h exp=1", resp_valid); else n_pass++;
    resp_ready = 1'b1; flush = 1'b1; req_valid = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL fhold_req_ready got=%0h exp=0", req_ready); else n_pass++;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fhold_drop got=%0h/%0h exp=0/0", resp_valid, busy); else n_pass++;
  endtask

  task automatic test_unsupported;
    send(4'b1101, 32'h12345678, 32'h9ABCDEF0, 5'd6);
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_rd !== 5'd6 || resp_int !== 1'b0)
      $display("FAIL unsup_resp got=%0h/%0h/%0h/%0h exp=1/0/6/0", resp_valid, resp_data, resp_rd, resp_int); else n_pass++;
    tick();
  endtask

  task automatic test_watchdog;
    hang = 1'b1;
    send(4'b0000, 32'h3F800000, 32'h3F800000, 5'd8);
    tick(30);
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL wdog_early got=%0h/%0h exp=0/1", err, busy); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b1 || busy !== 1'b1 || fpu_op !== 4'hF || resp_valid !== 1'b0)
      $display("FAIL wdog_fire got=%0h/%0h/%0h/%0h exp=1/1/f/0", err, busy, fpu_op, resp_valid); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || err !== 1'b1) $display("FAIL wdog_idle got=%0h/%0h exp=0/1", busy, err); else n_pass++;
    hang = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    send(4'b0000, 32'h3F800000, 32'h40000000, 5'd7);
    tick();
    n_checks++; if (busy !== 1'b1 || fpu_op !== 4'b0000) $display("FAIL arst_pre got=%0h/%0h exp=1/0", busy, fpu_op); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || fpu_op !== 4'hF || err !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL arst_ctrl got=%0h/%0h/%0h/%0h exp=0/f/0/0", busy, fpu_op, err, resp_valid); else n_pass++;
    n_checks++; if (fpu_src0 !== 32'h0 || resp_data !== 32'h0 || resp_rd !== '0)
      $display("FAIL arst_data got=%0h/%0h/%0h exp=0/0/0", fpu_src0, resp_data, resp_rd); else n_pass++;
    #3 rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fsgnj();
    test_fadd();
    test_hold_b2b();
    test_flush_exec();
    test_flush_hold();
    test_unsupported();
    test_watchdog();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Issue/handshake stage directly upstream of the FPU datapath.
- Accepts one FP operation from decode via valid/ready.
- Latches operands and opcode, and holds them stable on the FPU inputs until the FPU asserts fin.
- Captures the result into an output register that writeback drains via valid/ready. Supports pipeline flush and a hang watchdog.

Parameters:
- TIMEOUT_CYCLES, 31, max EXEC cycles without fin before abort (must be > 11, the longest FPU latency)
- RD_W, 5, destination register index width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- req_valid  in  1  decode presents an operation
- req_ready  out  1  block accepts the operation this cycle
- req_op  in  4  FPU opcode (fadd=0000 … fcvtsw=1100)
- req_src0  in  32  operand 0
- req_src1  in  32  operand 1
- req_rd  in  RD_W  destination register
- flush  in  1  kill in-flight and buffered operation
- fpu_op  out  4  opcode to FPU
- fpu_src0  out  32  operand 0 to FPU
- fpu_src1  out  32  operand 1 to FPU
- fpu_result  in  32  FPU result
- fpu_fin  in  1  FPU result valid for current fpu_op
- resp_valid  out  1  result available
- resp_ready  in  1  writeback consumes result
- resp_data  out  32  result
- resp_rd  out  RD_W  destination register
- resp_int  out  1  destination is the integer RF (op 1000/1001/1010/1011)
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; resp_valid=0, err=0.
  - resp_data/resp_rd/resp_int=0.
  - Operand/op latches=0; fpu_op=NOP (4'b1111).
- NOP (1111) is driven whenever no operation is in EXEC. FPU treats it as single-cycle (fin=1), so its internal counter returns to 0.
- States: IDLE, EXEC, DRAIN, HOLD.
- IDLE:
  - req_ready = !flush.
  - On req_valid&&req_ready, latch op/src/rd and go to EXEC.
- EXEC:
  - fpu_op/fpu_src* driven from latches, unchanged every cycle.
  - On fpu_fin: capture fpu_result, rd, resp_int into output register; resp_valid<=1; go to HOLD.
  - Latency: for FPU latency N (fadd/fsub 3, fmul 2, fdiv 11, fsqrt 7, fcvtsw 2, fcvtws 1, others 0), resp_valid rises after the (N+1)th clock edge following the accepting edge.
  - Example: fsgnj responds after edge 1; fadd after edge 4.
- HOLD:
  - fpu_op=NOP; resp_valid=1; outputs stable while resp_ready=0.
  - resp_ready=1 completes the response. req_ready = resp_ready && !flush, giving back-to-back accept in the same cycle.
  - If a new op is accepted, go to EXEC; else go to IDLE with resp_valid<=0.
- flush (highest priority, overrides fin and req):
  - In EXEC: discard; drive NOP for exactly one cycle in DRAIN, which resets the FPU counter; then IDLE. No response is produced.
  - In HOLD: resp_valid<=0; go to IDLE. The response is dropped even if resp_ready=1 in the same cycle.
  - In IDLE or DRAIN: no effect; req_ready=0.
- DRAIN: req_ready=0; go to IDLE next cycle.
- Watchdog:
  - A counter clears on EXEC entry and increments each EXEC cycle.
  - When it reaches TIMEOUT_CYCLES without fin: err<=1 (sticky until reset); go to DRAIN; no response.
- Unsupported ops (1101–1110): FPU returns fin=1 with result 0. The block completes them as single-cycle ops with resp_data=0.
- resp_int is decoded from the latched op at capture.
- Operand latches load only on accept; request inputs are ignored otherwise.

Decomposition:
- Shared package fpu_pkg:
  - fpuop_t enum (4-bit opcodes) and FPU_NOP constant.
  - Per-op latency constants.
  - Function is_int_dest(op).
  - Issue-state enum.
- The FPU datapath itself and this block both import fpu_pkg.
- No sub-module; the single FSM plus output register stays below 250 lines.

Test Plan:
- fsgnj (0101) src0=0x3F800000, src1=0xBF800000, resp_ready=1 -> resp_valid after edge 1, resp_data=0xBF800000, resp_int=0.
- fadd 0x3F800000+0x40000000, rd=7 -> fpu_op held 0000 for 4 cycles; resp_data=0x40400000, resp_rd=7 after edge 4.
- resp_ready=0 for 5 cycles after fmul result -> resp_data stable, req_ready=0; then resp_ready=1 with new req_valid -> same-cycle accept, next op enters EXEC.
- flush on 5th EXEC cycle of fdiv -> no resp_valid, one DRAIN cycle with fpu_op=1111, then fcvtws (1011) of 0x40400000 returns 3 with resp_int=1.
- Stubbed FPU never asserts fin -> err=1 after 31 EXEC cycles, DRAIN then IDLE, busy=0.
- rstn deasserted asynchronously mid-EXEC -> all outputs at reset values immediately, fpu_op=1111.
